// File: rtl/qosc_multi.sv
// qosc_multi: bank of NCH time-multiplexed quadrature oscillators with amplitude correction.
// Define QOSC_SAT_EN to saturate the corrected sample instead of wrapping it.
module qosc_multi #(
    parameter int WIDTH = 16,
    parameter int NCH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [3:0]              cfg_ch,
    input  logic signed [WIDTH-1:0] cfg_re_coeff,
    input  logic signed [WIDTH-1:0] cfg_im_coeff,
    input  logic signed [WIDTH-1:0] cfg_power,
    input  logic signed [WIDTH-1:0] cfg_init_re,
    input  logic signed [WIDTH-1:0] cfg_init_im,
    output logic                    cfg_ready,
    input  logic [NCH-1:0]          ch_en,
    input  logic                    step,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0]              out_ch,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic                    overrun,
    input  logic                    clr_ovr
);
    localparam int T = 2*WIDTH+2;
    localparam int P = 2*WIDTH+4;
    localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
    typedef enum logic [1:0] {IDLE, ROT, CORR, EMIT} state_t;
    state_t state;
    logic signed [WIDTH-1:0] cre [NCH];
    logic signed [WIDTH-1:0] cim [NCH];
    logic signed [WIDTH-1:0] pwr [NCH];
    logic signed [WIDTH-1:0] are [NCH];
    logic signed [WIDTH-1:0] aim [NCH];
    logic [NCH-1:0] mask;
    logic signed [T-1:0] t_re, t_im;
    logic signed [WIDTH-1:0] h_re, h_im, t0, n_re, n_im;
    logic signed [P-1:0] rot_re, rot_im, ac;
    logic [CW-1:0] idx;
    logic [3:0] first, nxt;
    logic has_nxt;
`ifdef QOSC_SAT_EN
    localparam logic signed [P-1:0] SMAX = P'((64'sd1 <<< (WIDTH-1)) - 64'sd1);
    localparam logic signed [P-1:0] SMIN = -SMAX - P'(1);
    function automatic logic signed [WIDTH-1:0] fit(input logic signed [P-1:0] v);
        return v > SMAX ? WIDTH'(SMAX) : v < SMIN ? WIDTH'(SMIN) : WIDTH'(v);
    endfunction
`else
    function automatic logic signed [WIDTH-1:0] fit(input logic signed [P-1:0] v);
        return WIDTH'(v);
    endfunction
`endif
    assign idx = out_ch[CW-1:0];
    assign cfg_ready = state == IDLE;
    assign busy = state != IDLE;
    assign rot_re = P'(are[idx]) * P'(cre[idx]) - P'(aim[idx]) * P'(cim[idx]);
    assign rot_im = P'(are[idx]) * P'(cim[idx]) + P'(aim[idx]) * P'(cre[idx]);
    // t0 ~ (power - |h|^2) is the first-order gain correction pulling |acc| back toward sqrt(power)
    assign ac = (P'(pwr[idx]) <<< WIDTH) - P'(h_re) * P'(h_re) - P'(h_im) * P'(h_im);
    assign t0 = WIDTH'(ac >>> WIDTH);
    assign n_re = fit((P'(t_re) + P'(h_re) * P'(t0)) >>> (WIDTH-1));
    assign n_im = fit((P'(t_im) + P'(h_im) * P'(t0)) >>> (WIDTH-1));
    always_comb begin
        first = '0;
        nxt = '0;
        has_nxt = 1'b0;
        for (int i = NCH-1; i >= 0; i--) begin
            first = ch_en[i] ? 4'(i) : first;
            nxt = (mask[i] && i > int'(out_ch)) ? 4'(i) : nxt;
            has_nxt = has_nxt | (mask[i] && i > int'(out_ch));
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            out_valid <= 1'b0;
            out_ch <= '0;
            out_re <= '0;
            out_im <= '0;
            overrun <= 1'b0;
            mask <= '0;
            t_re <= '0;
            t_im <= '0;
            h_re <= '0;
            h_im <= '0;
            for (int i = 0; i < NCH; i++) begin
                cre[i] <= '0;
                cim[i] <= '0;
                pwr[i] <= '0;
                are[i] <= '0;
                aim[i] <= '0;
            end
        end else begin
            overrun <= (step && state != IDLE) || (overrun && !clr_ovr);
            case (state)
                IDLE: begin
                    if (cfg_we && 32'(cfg_ch) < NCH) begin
                        cre[cfg_ch[CW-1:0]] <= cfg_re_coeff;
                        cim[cfg_ch[CW-1:0]] <= cfg_im_coeff;
                        pwr[cfg_ch[CW-1:0]] <= cfg_power;
                        are[cfg_ch[CW-1:0]] <= cfg_init_re;
                        aim[cfg_ch[CW-1:0]] <= cfg_init_im;
                    end
                    if (step && |ch_en) begin
                        mask <= ch_en;
                        out_ch <= first;
                        state <= ROT;
                    end
                end
                ROT: begin
                    t_re <= T'(rot_re);
                    t_im <= T'(rot_im);
                    h_re <= WIDTH'(rot_re >>> (WIDTH-1));
                    h_im <= WIDTH'(rot_im >>> (WIDTH-1));
                    state <= CORR;
                end
                CORR: begin
                    are[idx] <= n_re;
                    aim[idx] <= n_im;
                    out_re <= n_re;
                    out_im <= n_im;
                    out_valid <= 1'b1;
                    state <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_ch <= has_nxt ? nxt : out_ch;
                        state <= has_nxt ? ROT : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qosc_multi.sv
// tb_qosc_multi: directed stimulus for qosc_multi checked against a per-channel arithmetic model.
module tb_qosc_multi;
    localparam int W = 16;
    localparam int NCH = 4;
    logic clk = 1'b0, rst, cfg_we, step, out_ready, clr_ovr;
    logic [3:0] cfg_ch;
    logic signed [W-1:0] cfg_re_coeff, cfg_im_coeff, cfg_power, cfg_init_re, cfg_init_im;
    logic [NCH-1:0] ch_en;
    logic cfg_ready, busy, out_valid, overrun;
    logic [3:0] out_ch;
    logic signed [W-1:0] out_re, out_im;
    int n_cmp = 0, n_bad = 0, hs = 0;
    typedef struct {int ch; longint re; longint im;} exp_t;
    exp_t q[$];
    longint m_re[NCH], m_im[NCH], m_cr[NCH], m_ci[NCH], m_pw[NCH];

    qosc_multi #(.WIDTH(W), .NCH(NCH)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_re_coeff(cfg_re_coeff), .cfg_im_coeff(cfg_im_coeff), .cfg_power(cfg_power),
        .cfg_init_re(cfg_init_re), .cfg_init_im(cfg_init_im), .cfg_ready(cfg_ready),
        .ch_en(ch_en), .step(step), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch), .out_re(out_re), .out_im(out_im), .overrun(overrun), .clr_ovr(clr_ovr)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint wrapw(input longint v);
        longint r;
        r = v & ((64'sd1 <<< W) - 1);
        return r >= (64'sd1 <<< (W-1)) ? r - (64'sd1 <<< W) : r;
    endfunction

    function automatic longint fitw(input longint v);
`ifdef QOSC_SAT_EN
        return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
`else
        return wrapw(v);
`endif
    endfunction

    // one oscillator step: rotate by the coefficient, then scale by (1 + (power - |h|^2)) in Q-format
    task automatic adv(input int c);
        longint tr, ti, hr, hi, t0, one;
        one = 64'sd1 <<< (W-1);
        tr = m_re[c]*m_cr[c] - m_im[c]*m_ci[c];
        ti = m_re[c]*m_ci[c] + m_im[c]*m_cr[c];
        hr = wrapw(tr >>> (W-1));
        hi = wrapw(ti >>> (W-1));
        t0 = wrapw((m_pw[c]*(2*one) - hr*hr - hi*hi) >>> W);
        m_re[c] = fitw((tr + hr*t0) >>> (W-1));
        m_im[c] = fitw((ti + hi*t0) >>> (W-1));
        q.push_back('{c, m_re[c], m_im[c]});
    endtask

    task automatic model_reset();
        q.delete();
        for (int c = 0; c < NCH; c++) begin
            m_re[c] = 0; m_im[c] = 0; m_cr[c] = 0; m_ci[c] = 0; m_pw[c] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int c, input longint rc, input longint ic, input longint pw,
                       input longint ir, input longint ii, input bit busy_now);
        cfg_we = 1'b1; cfg_ch = 4'(c);
        cfg_re_coeff = 16'(rc); cfg_im_coeff = 16'(ic); cfg_power = 16'(pw);
        cfg_init_re = 16'(ir); cfg_init_im = 16'(ii);
        tick();
        cfg_we = 1'b0;
        if (!busy_now && c < NCH) begin
            m_cr[c] = rc; m_ci[c] = ic; m_pw[c] = pw; m_re[c] = ir; m_im[c] = ii;
        end
    endtask

    task automatic start(input logic [NCH-1:0] m);
        ch_en = m; step = 1'b1;
        for (int c = 0; c < NCH; c++) if (m[c]) adv(c);
        tick();
        step = 1'b0;
    endtask

    task automatic first_out(output int n, output longint c, output longint r, output longint i);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        if (!out_valid) check("first_out_timeout", 0, 1);
        c = out_ch; r = out_re; i = out_im;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 60);
        check("wait_idle_busy", busy, 0);
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_valid", out_valid, 0);
                end else begin
                    check("stream_ch", out_ch, q[0].ch);
                    check("stream_re", out_re, q[0].re);
                    check("stream_im", out_im, q[0].im);
                    if (out_ready) begin
                        void'(q.pop_front());
                        hs++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int n, h0;
        longint c, r, i, c0, r0, i0;
        rst = 1'b1; cfg_we = 1'b0; step = 1'b0; clr_ovr = 1'b0; out_ready = 1'b1;
        cfg_ch = '0; ch_en = '0;
        cfg_re_coeff = '0; cfg_im_coeff = '0; cfg_power = '0; cfg_init_re = '0; cfg_init_im = '0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cfg_ready, 1);
        check("rst_overrun", overrun, 0);
        check("rst_ch", out_ch, 0);
        check("rst_re", out_re, 0);
        check("rst_im", out_im, 0);
        start('0);
        @(negedge clk);
        check("empty_mask_busy", busy, 0);
        // unit-gain rotation, ch0
        cfg(0, 32767, 0, 4096, 16384, 0, 0);
        start(4'b0001);
        @(negedge clk);
        check("lat_c1_busy", busy, 1);
        check("lat_c1_valid", out_valid, 0);
        @(negedge clk);
        check("lat_c2_valid", out_valid, 0);
        @(negedge clk);
        check("lat_c3_valid", out_valid, 1);
        check("r028_ch", out_ch, 0);
        check("r028_re", out_re, 16383);
        check("r028_im", out_im, 0);
        wait_idle();
        // quarter-turn rotation, ch1, two steps
        cfg(1, 0, 32767, 4096, 16384, 0, 0);
        start(4'b0010);
        first_out(n, c, r, i);
        check("r029a_ch", c, 1);
        check("r029a_re", r, 0);
        check("r029a_im", i, 16383);
        wait_idle();
        start(4'b0010);
        first_out(n, c, r, i);
        check("r029b_re", r, -16383);
        check("r029b_im", i, 0);
        wait_idle();
        // two-channel sweep with back-pressure, overrun and dropped writes
        cfg(2, 23170, 23170, 1000, 1000, -2000, 0);
        out_ready = 1'b0;
        h0 = hs;
        start(4'b0101);
        ch_en = 4'b1111; step = 1'b1;
        tick();
        step = 1'b0;
        @(negedge clk);
        check("ovr_set", overrun, 1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        @(negedge clk);
        check("ovr_clr", overrun, 0);
        step = 1'b1; clr_ovr = 1'b1;
        tick();
        step = 1'b0; clr_ovr = 1'b0;
        @(negedge clk);
        check("ovr_set_wins", overrun, 1);
        cfg(3, 5000, 5000, 5000, 5000, 5000, 1);
        cfg(7, 1234, 1234, 1234, 1234, 1234, 1);
        first_out(n, c0, r0, i0);
        check("hold_first_ch", c0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_ch", out_ch, c0);
            check("hold_re", out_re, r0);
            check("hold_im", out_im, i0);
        end
        tick();
        out_ready = 1'b1;
        wait_idle();
        check("r030_handshakes", hs - h0, 2);
        check("ovr_sticky", overrun, 1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        @(negedge clk);
        check("ovr_cleared", overrun, 0);
        // back-to-back spacing with out_ready held high
        start(4'b0101);
        first_out(n, c, r, i);
        check("spacing_first", n, 3);
        n = 0;
        do begin @(negedge clk); n++; end while (!(out_valid && out_ch == 4'd2) && n < 20);
        check("spacing_gap", n, 3);
        wait_idle();
        // channel 3 never accepted a write
        start(4'b1000);
        first_out(n, c, r, i);
        check("ch3_ch", c, 3);
        check("ch3_re", r, 0);
        check("ch3_im", i, 0);
        wait_idle();
        // full-scale, saturating vs wrapping
        cfg(0, 32767, 0, 32767, 32767, 0, 0);
        start(4'b0001);
        first_out(n, c, r, i);
`ifdef QOSC_SAT_EN
        check("r031_re", r, 32767);
`else
        check("r031_re", r, -16387);
`endif
        check("r031_im", i, 0);
        wait_idle();
        // reset mid-sweep
        cfg(1, 100, 200, 300, 400, 500, 0);
        start(4'b0011);
        tick();
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("r032_valid", out_valid, 0);
        check("r032_busy", busy, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("r032_quiet", out_valid, 0);
        end
        h0 = hs;
        start(4'b1111);
        wait_idle();
        check("r032_handshakes", hs - h0, 4);
        check("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
